// File: rtl/tc_ram_read_port.sv
// tc_ram_read_port: one read port of tc_multi_port_ram.
//   Checks the read address against the memory depth, forces the data to zero
//   when the port is idle, the RAM is clearing or the address is out of range,
//   and optionally registers the result. At READ_LATENCY=1 with RDW_MODE=1, a
//   same-edge write to the read address is forwarded as the lane-merged word.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          read enable for this port
//   busy          clear sequence running in the parent RAM
//   address       read address (full ADDR_WIDTH, never truncated for the check)
//   rd_idx        memory index presented to the parent array
//   rd_word       word the parent array returns for rd_idx
//   wr_en         write actually committing on this edge
//   wr_address    write address
//   wr_word       lane-merged word being written
//   out           read data
//   rd_oob        active read to an out-of-range address
module tc_ram_read_port #(
  parameter int ADDR_WIDTH   = 16,
  parameter int BIT_WIDTH    = 16,
  parameter int BIT_DEPTH    = 256,
  parameter int IDX_W        = 8,
  parameter int READ_LATENCY = 0,
  parameter int RDW_MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  busy,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [IDX_W-1:0]      rd_idx,
  input  logic [BIT_WIDTH-1:0]  rd_word,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [BIT_WIDTH-1:0]  wr_word,
  output logic [BIT_WIDTH-1:0]  out,
  output logic                  rd_oob
);

  // One extra bit so a depth of exactly 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(BIT_DEPTH);

  logic                 in_range;
  logic                 collide;
  logic [BIT_WIDTH-1:0] src_word;
  logic [BIT_WIDTH-1:0] out_d;
  logic [BIT_WIDTH-1:0] out_q;

  always_comb begin
    in_range = ({1'b0, address} < DEPTH_X);
    rd_idx   = address[IDX_W-1:0];
    // Forwarding only makes sense for the registered read; a combinational
    // read sees the new word naturally once the write edge has passed.
    collide  = (RDW_MODE == 1) && (READ_LATENCY == 1) && wr_en && (wr_address == address);
    src_word = collide ? wr_word : rd_word;
    out_d    = (load && !busy && !rst && in_range) ? src_word : '0;
    rd_oob   = load && !in_range;
  end

  // ---- registered read stage ----
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out = (READ_LATENCY == 0) ? out_d : out_q;

endmodule

// File: rtl/tc_multi_port_ram.sv
// tc_multi_port_ram: parametrised RAM with READ_PORTS independent read ports,
//   byte-lane write enables, 0/1-cycle read latency and selectable
//   read-during-write behaviour. Reset starts a clear that zeroes one word per
//   cycle while busy is high; during that time writes are ignored, every read
//   port returns zero and addr_err is suppressed.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   save        write request
//   wr_address  write address
//   wr_lanes    per-lane write enables (LANES = BIT_WIDTH/BYTE_WIDTH)
//   in          write data
//   load        per-port read enables
//   address     packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   out         packed read data, port k at [k*BIT_WIDTH +: BIT_WIDTH]
//   busy        clear sequence in progress
//   addr_err    one-cycle pulse after an out-of-range save or load
module tc_multi_port_ram #(
  parameter int    UUID         = 0,
  parameter string NAME         = "",
  parameter int    BIT_WIDTH    = 16,
  parameter int    BIT_DEPTH    = 256,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    READ_PORTS   = 2,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    READ_LATENCY = 0,
  parameter int    RDW_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             save,
  input  logic [ADDR_WIDTH-1:0]            wr_address,
  input  logic [BIT_WIDTH/BYTE_WIDTH-1:0]  wr_lanes,
  input  logic [BIT_WIDTH-1:0]             in,
  input  logic [READ_PORTS-1:0]            load,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] address,
  output logic [READ_PORTS*BIT_WIDTH-1:0]  out,
  output logic                             busy,
  output logic                             addr_err
);

  localparam int LANES = BIT_WIDTH / BYTE_WIDTH;
  localparam int CLR_W = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
  localparam logic [CLR_W-1:0]      LAST_PTR = CLR_W'(BIT_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(BIT_DEPTH);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CLR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic                addr_err_q, addr_err_d;

  logic [BIT_WIDTH-1:0] mem_q [BIT_DEPTH];

  logic                 wr_in_range;
  logic [CLR_W-1:0]     wr_idx;
  logic [BIT_WIDTH-1:0] wr_cur;
  logic [BIT_WIDTH-1:0] wr_merged;
  logic                 wr_en;

  logic [CLR_W-1:0]      rd_idx  [READ_PORTS];
  logic [BIT_WIDTH-1:0]  rd_word [READ_PORTS];
  logic [READ_PORTS-1:0] rd_oob;

  // Write path: enabled lanes come from in, the rest from the stored word.
  always_comb begin
    wr_in_range = ({1'b0, wr_address} < DEPTH_X);
    wr_idx      = wr_address[CLR_W-1:0];
    wr_cur      = mem_q[wr_idx];
    wr_merged   = wr_cur;
    for (int j = 0; j < LANES; j++) begin
      if (wr_lanes[j]) wr_merged[j*BYTE_WIDTH +: BYTE_WIDTH] = in[j*BYTE_WIDTH +: BYTE_WIDTH];
    end
    wr_en = !rst && (state_q == IDLE) && save && wr_in_range && (|wr_lanes);
  end

  // Clear sequencer and error pulse.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    addr_err_d = 1'b0;
    if (rst) begin
      state_d   = CLEAR;
      clr_ptr_d = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LAST_PTR) begin
            state_d   = IDLE;
            clr_ptr_d = '0;
          end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
          end
        end
        default: addr_err_d = (save && !wr_in_range) || (|rd_oob);
      endcase
    end
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    clr_ptr_q  <= clr_ptr_d;
    addr_err_q <= addr_err_d;
  end

  // ---- memory array ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem_q[clr_ptr_q] <= '0;
      else if (wr_en)       mem_q[wr_idx]    <= wr_merged;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign addr_err = addr_err_q;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_port
    assign rd_word[k] = mem_q[rd_idx[k]];

    tc_ram_read_port #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .BIT_WIDTH    (BIT_WIDTH),
      .BIT_DEPTH    (BIT_DEPTH),
      .IDX_W        (CLR_W),
      .READ_LATENCY (READ_LATENCY),
      .RDW_MODE     (RDW_MODE)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .load       (load[k]),
      .busy       (busy),
      .address    (address[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .rd_idx     (rd_idx[k]),
      .rd_word    (rd_word[k]),
      .wr_en      (wr_en),
      .wr_address (wr_address),
      .wr_word    (wr_merged),
      .out        (out[k*BIT_WIDTH +: BIT_WIDTH]),
      .rd_oob     (rd_oob[k])
    );
  end

endmodule
